// File: rtl/rggen_avalon_bridge.sv
// Registered Avalon-MM bridge in front of the RgGen Avalon adapter, with one transaction in flight.
// Optional downstream timeout abort is enabled by defining RGGEN_AVALON_BRIDGE_TIMEOUT_EN.
module rggen_avalon_bridge #(
  parameter int                        ADDRESS_WIDTH     = 8,
  parameter int                        BUS_WIDTH         = 32,
  parameter int                        TIMEOUT_CYCLES    = 256,
  parameter logic [BUS_WIDTH-1:0]      DEFAULT_READ_DATA = '0
) (
  input  logic                         i_clk,
  input  logic                         i_rst_n,
  input  logic                         i_s_read,
  input  logic                         i_s_write,
  input  logic [ADDRESS_WIDTH-1:0]     i_s_address,
  input  logic [BUS_WIDTH-1:0]         i_s_writedata,
  input  logic [BUS_WIDTH/8-1:0]       i_s_byteenable,
  output logic                         o_s_waitrequest,
  output logic [BUS_WIDTH-1:0]         o_s_readdata,
  output logic [1:0]                   o_s_response,
  output logic                         o_m_read,
  output logic                         o_m_write,
  output logic [ADDRESS_WIDTH-1:0]     o_m_address,
  output logic [BUS_WIDTH-1:0]         o_m_writedata,
  output logic [BUS_WIDTH/8-1:0]       o_m_byteenable,
  input  logic                         i_m_waitrequest,
  input  logic [BUS_WIDTH-1:0]         i_m_readdata,
  input  logic [1:0]                   i_m_response
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    RSP  = 2'd2
  } state_t;

  state_t state;
  state_t state_next;
  logic   capture;
  logic   ack;
  logic   abort;
  logic   timeout_hit;

`ifdef RGGEN_AVALON_BRIDGE_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT_CYCLES);

  logic [CNT_W-1:0] timeout_count;

  // Counter holds the number of REQ cycles already spent waiting.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      timeout_count <= '0;
    end else if (capture) begin
      timeout_count <= '0;
    end else if ((state == REQ) && i_m_waitrequest) begin
      timeout_count <= timeout_count + 1'b1;
    end
  end

  assign timeout_hit = (state == REQ) && i_m_waitrequest &&
                       (timeout_count == CNT_W'(TIMEOUT_CYCLES - 1));
`else
  logic unused_timeout;
  assign unused_timeout = ^TIMEOUT_CYCLES;
  assign timeout_hit    = 1'b0;
`endif

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    capture    = 1'b0;
    ack        = 1'b0;
    abort      = 1'b0;
    case (state)
      IDLE: begin
        if (i_s_read || i_s_write) begin
          capture    = 1'b1;
          state_next = REQ;
        end
      end
      REQ: begin
        // An ack arriving on the expiry cycle takes precedence over the abort.
        if (!i_m_waitrequest) begin
          ack        = 1'b1;
          state_next = RSP;
        end else if (timeout_hit) begin
          abort      = 1'b1;
          state_next = RSP;
        end
      end
      RSP: begin
        state_next = IDLE;
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      o_m_read       <= 1'b0;
      o_m_write      <= 1'b0;
      o_m_address    <= '0;
      o_m_writedata  <= '0;
      o_m_byteenable <= '0;
      o_s_readdata   <= '0;
      o_s_response   <= 2'b00;
    end else begin
      if (capture) begin
        // Read wins when both strobes are set; write data is still latched.
        o_m_read       <= i_s_read;
        o_m_write      <= !i_s_read;
        o_m_address    <= i_s_address;
        o_m_writedata  <= i_s_writedata;
        o_m_byteenable <= i_s_byteenable;
      end
      if (ack || abort) begin
        o_m_read  <= 1'b0;
        o_m_write <= 1'b0;
      end
      if (ack) begin
        o_s_readdata <= i_m_readdata;
        o_s_response <= i_m_response;
      end else if (abort) begin
        o_s_readdata <= DEFAULT_READ_DATA;
        o_s_response <= 2'b10;
      end
    end
  end

  assign o_s_waitrequest = (state != RSP);

endmodule

// File: tb/tb_rggen_avalon_bridge.sv
// Randomized bench for rggen_avalon_bridge: transaction-level timeline model checked every cycle.
// Models the abort path too when RGGEN_AVALON_BRIDGE_TIMEOUT_EN is defined.
module tb_rggen_avalon_bridge;

  localparam int          TO  = 4;
  localparam logic [31:0] DEF = 32'hBAD0_BAD0;
`ifdef RGGEN_AVALON_BRIDGE_TIMEOUT_EN
  localparam bit TO_EN = 1'b1;
`else
  localparam bit TO_EN = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst_n;
  logic        s_read, s_write;
  logic [7:0]  s_address;
  logic [31:0] s_writedata;
  logic [3:0]  s_byteenable;
  logic        s_waitrequest;
  logic [31:0] s_readdata;
  logic [1:0]  s_response;
  logic        m_read, m_write;
  logic [7:0]  m_address;
  logic [31:0] m_writedata;
  logic [3:0]  m_byteenable;
  logic        m_waitrequest;
  logic [31:0] m_readdata;
  logic [1:0]  m_response;

  rggen_avalon_bridge #(
    .ADDRESS_WIDTH(8), .BUS_WIDTH(32), .TIMEOUT_CYCLES(TO), .DEFAULT_READ_DATA(DEF)
  ) dut (
    .i_clk(clk), .i_rst_n(rst_n),
    .i_s_read(s_read), .i_s_write(s_write), .i_s_address(s_address),
    .i_s_writedata(s_writedata), .i_s_byteenable(s_byteenable),
    .o_s_waitrequest(s_waitrequest), .o_s_readdata(s_readdata), .o_s_response(s_response),
    .o_m_read(m_read), .o_m_write(m_write), .o_m_address(m_address),
    .o_m_writedata(m_writedata), .o_m_byteenable(m_byteenable),
    .i_m_waitrequest(m_waitrequest), .i_m_readdata(m_readdata), .i_m_response(m_response)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_vec = 0;
  int n_bad = 0;

  // Expected per-cycle outputs, set by the stimulus from the transaction timeline.
  bit          chk_en = 1'b0;
  logic        exp_wait, exp_mrd, exp_mwr, exp_cmd;
  logic [7:0]  exp_addr;
  logic [31:0] exp_wdata;
  logic [3:0]  exp_be;
  logic [31:0] exp_rdata;
  logic [1:0]  exp_resp;
  int          start_cyc, done_cyc;
  logic [31:0] done_rdata;
  logic [1:0]  done_resp;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s at t=%0t: got 0x%08h expected 0x%08h", nm, $time, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (chk_en) begin
      check("s_waitrequest", 32'(s_waitrequest), 32'(exp_wait));
      check("m_read",        32'(m_read),        32'(exp_mrd));
      check("m_write",       32'(m_write),       32'(exp_mwr));
      check("s_readdata",    s_readdata,         exp_rdata);
      check("s_response",    32'(s_response),    32'(exp_resp));
      if (exp_cmd) begin
        check("m_address",    32'(m_address),    32'(exp_addr));
        check("m_writedata",  m_writedata,       exp_wdata);
        check("m_byteenable", 32'(m_byteenable), 32'(exp_be));
      end
      if (!s_waitrequest) begin
        done_cyc   = cyc - start_cyc;
        done_rdata = s_readdata;
        done_resp  = s_response;
      end
    end
  end

  // One host transaction; downstream acks after n wait cycles.
  task automatic run_txn(input logic rd, input logic wr, input logic [7:0] a,
                         input logic [31:0] wd, input logic [3:0] b, input int n,
                         input logic [1:0] rsp, input logic [31:0] rdat);
    bit abort;
    int last;
    abort = TO_EN && (n >= TO);
    last  = abort ? TO : n + 1;
    s_read = rd; s_write = wr; s_address = a; s_writedata = wd; s_byteenable = b;
    m_waitrequest = 1'($urandom); m_readdata = $urandom; m_response = 2'($urandom);
    exp_wait = 1'b1; exp_mrd = 1'b0; exp_mwr = 1'b0; exp_cmd = 1'b0;
    start_cyc = cyc; done_cyc = -1;
    @(posedge clk); #1;
    for (int k = 1; k <= last; k++) begin
      exp_mrd = rd; exp_mwr = !rd; exp_cmd = 1'b1;
      exp_addr = a; exp_wdata = wd; exp_be = b;
      s_address = 8'($urandom); s_writedata = $urandom; s_byteenable = 4'($urandom);
      if (k == n + 1) begin
        m_waitrequest = 1'b0; m_readdata = rdat; m_response = rsp;
      end else begin
        m_waitrequest = 1'b1; m_readdata = $urandom; m_response = 2'($urandom);
      end
      @(posedge clk); #1;
    end
    exp_wait = 1'b0; exp_mrd = 1'b0; exp_mwr = 1'b0; exp_cmd = 1'b0;
    exp_rdata = abort ? DEF : rdat;
    exp_resp  = abort ? 2'b10 : rsp;
    m_waitrequest = 1'($urandom); m_readdata = $urandom; m_response = 2'($urandom);
    @(posedge clk); #1;
    s_read = 1'b0; s_write = 1'b0; exp_wait = 1'b1;
  endtask

  initial begin
    int kind, gap;
    logic rd, wr;
    rst_n = 1'b0;
    s_read = 1'b0; s_write = 1'b0; s_address = '0; s_writedata = '0; s_byteenable = '0;
    m_waitrequest = 1'b1; m_readdata = '0; m_response = '0;
    exp_wait = 1'b1; exp_mrd = 1'b0; exp_mwr = 1'b0; exp_cmd = 1'b0;
    exp_addr = '0; exp_wdata = '0; exp_be = '0; exp_rdata = '0; exp_resp = '0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_waitrequest", 32'(s_waitrequest), 32'd1);
    check("rst_m_read",      32'(m_read),        32'd0);
    check("rst_m_address",   32'(m_address),     32'd0);
    check("rst_s_readdata",  s_readdata,         32'd0);
    rst_n = 1'b1;
    chk_en = 1'b1;
    @(posedge clk); #1;

    run_txn(1'b0, 1'b1, 8'h10, 32'hDEADBEEF, 4'hF, 0, 2'b00, 32'h0BAD_F00D);
    check("wr_latency", 32'(done_cyc), 32'd2);
    check("wr_response", 32'(done_resp), 32'd0);
    run_txn(1'b1, 1'b0, 8'h20, 32'h0, 4'hF, 3, 2'b00, 32'h12345678);
    check("rd_latency", 32'(done_cyc), 32'd5);
    check("rd_data", done_rdata, 32'h12345678);
    run_txn(1'b1, 1'b1, 8'h04, 32'h55AA55AA, 4'h3, 1, 2'b00, 32'hCAFEF00D);
    check("both_data", done_rdata, 32'hCAFEF00D);
    run_txn(1'b1, 1'b0, 8'h08, 32'h0, 4'hF, 2, 2'b11, 32'hA5A5A5A5);
    check("decerr_resp", 32'(done_resp), 32'd3);
    check("decerr_data", done_rdata, 32'hA5A5A5A5);
`ifdef RGGEN_AVALON_BRIDGE_TIMEOUT_EN
    run_txn(1'b1, 1'b0, 8'h44, 32'h0, 4'hF, 20, 2'b00, 32'h11111111);
    check("to_latency", 32'(done_cyc), 32'd5);
    check("to_resp", 32'(done_resp), 32'd2);
    check("to_data", done_rdata, DEF);
`endif

    // Reset while the downstream read is stalled.
    s_read = 1'b1; s_address = 8'h33; m_waitrequest = 1'b1;
    exp_mrd = 1'b0; exp_mwr = 1'b0; exp_cmd = 1'b0;
    @(posedge clk); #1;
    exp_mrd = 1'b1; exp_cmd = 1'b1; exp_addr = 8'h33; exp_wdata = s_writedata; exp_be = s_byteenable;
    @(posedge clk); #1;
    chk_en = 1'b0;
    #1 rst_n = 1'b0;
    #1;
    check("midrst_m_read",      32'(m_read),        32'd0);
    check("midrst_waitrequest", 32'(s_waitrequest), 32'd1);
    check("midrst_m_address",   32'(m_address),     32'd0);
    check("midrst_s_response",  32'(s_response),    32'd0);
    s_read = 1'b0;
    exp_mrd = 1'b0; exp_cmd = 1'b0; exp_wait = 1'b1; exp_rdata = '0; exp_resp = '0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    chk_en = 1'b1;
    @(posedge clk); #1;
    run_txn(1'b1, 1'b0, 8'h7E, 32'h0, 4'hF, 1, 2'b00, 32'h600DCAFE);
    check("post_rst_data", done_rdata, 32'h600DCAFE);

    for (int t = 0; t < 200; t++) begin
      kind = int'($urandom_range(0, 2));
      rd = (kind != 1);
      wr = (kind != 0);
      run_txn(rd, wr, 8'($urandom), $urandom, 4'($urandom), int'($urandom_range(0, 6)),
              2'($urandom), $urandom);
      gap = int'($urandom_range(0, 2));
      for (int g = 0; g < gap; g++) begin
        m_waitrequest = 1'($urandom); m_readdata = $urandom;
        @(posedge clk); #1;
      end
    end

    chk_en = 1'b0;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
